// File: rtl/alu_md_seq.sv
// Sequential integer ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide with valid/ready handshakes.
module alu_md_seq #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLT    = 5'd2;
  localparam logic [4:0] OP_SLTU   = 5'd3;
  localparam logic [4:0] OP_AND    = 5'd4;
  localparam logic [4:0] OP_OR     = 5'd5;
  localparam logic [4:0] OP_XOR    = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_LUI    = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [4:0]      op_q;
  logic [XLEN-1:0] hi, lo, opnd;
  logic            neg_res, neg_rem, div0;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, mag1, mag2, step_hi, step_lo, md_res;
  logic [XLEN-1:0] quot_fix, rem_fix;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN:0]   mul_sum, div_trial;
  logic            is_md, is_div, s1_signed, s2_signed, s1_neg, s2_neg;

  assign shamt  = src2[SHW-1:0];
  assign is_md  = (op >= OP_MUL) && (op <= OP_REMU);
  assign is_div = (op >= OP_DIV);
  assign s1_neg = s1_signed & src1[XLEN-1];
  assign s2_neg = s2_signed & src2[XLEN-1];
  assign mag1   = s1_neg ? -src1 : src1;
  assign mag2   = s2_neg ? -src2 : src2;

  // Single-cycle operations
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_SLT:  alu_res = XLEN'($signed(src1) < $signed(src2));
      OP_SLTU: alu_res = XLEN'(src1 < src2);
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SLL:  alu_res = src1 << shamt;
      OP_SRL:  alu_res = src1 >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(src1) >>> shamt);
      OP_LUI:  alu_res = src2;
      default: alu_res = '0;
    endcase
  end

  // Operand signedness for the iterative ops
  always_comb begin
    s1_signed = 1'b0;
    s2_signed = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        s1_signed = 1'b1;
        s2_signed = 1'b1;
      end
      OP_MULHSU: s1_signed = 1'b1;
      default: ;
    endcase
  end

  // One multiply or divide iteration on {hi, lo}; opnd is multiplicand/divisor
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_trial = {hi, lo[XLEN-1]} - {1'b0, opnd};
    if (op_q >= OP_DIV) begin
      if (!div_trial[XLEN]) begin
        step_hi = div_trial[XLEN-1:0];
        step_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        step_hi = {hi[XLEN-2:0], lo[XLEN-1]};
        step_lo = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // Sign restoration and result select after the final iteration
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_res ? -prod : prod;
    quot_fix = neg_res ? -step_lo : step_lo;
    rem_fix  = neg_rem ? -step_hi : step_hi;
    case (op_q)
      OP_MUL:                       md_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              md_res = div0 ? '1 : quot_fix;
      default:                      md_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      op_q      <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div0      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            op_q     <= op;
            if (is_md) begin
              state   <= CALC;
              cnt     <= CW'(XLEN);
              hi      <= '0;
              lo      <= is_div ? mag1 : mag2;
              opnd    <= is_div ? mag2 : mag1;
              neg_res <= s1_neg ^ s2_neg;
              neg_rem <= s1_neg;
              div0    <= (src2 == '0);
            end else begin
              state     <= DONE;
              result    <= alu_res;
              out_valid <= 1'b1;
            end
          end
        end
        CALC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            result    <= md_res;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_seq.sv
// Directed self-checking bench for alu_md_seq at XLEN = 32.
module tb_alu_md_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  alu_md_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble inputs while busy, check result and latency
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'd0; src1 = ~a; src2 = ~b;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check(tag, result, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int pulses;

    @(posedge clk); #2;
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_v", 32'(out_valid), 32'd0);
    check("rst_res", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("add_ovf", 5'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
    run_op("sub",     5'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
    run_op("slt",     5'd2, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
    run_op("sltu",    5'd3, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
    run_op("and",     5'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
    run_op("or",      5'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1);
    run_op("xor",     5'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
    run_op("sll",     5'd7, 32'h00000001, 32'h00000021, 32'h00000002, 1);
    run_op("srl",     5'd8, 32'h80000000, 32'h00000004, 32'h08000000, 1);
    run_op("sra",     5'd9, 32'h80000000, 32'h00000024, 32'hF8000000, 1);
    run_op("lui",     5'd10, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 1);
    run_op("op25",    5'd25, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);

    run_op("mul_m1",    5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op("mulhu_m1",  5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh_m1",   5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhsu_m1", 5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("mul_neg",   5'd11, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFF1, 33);
    run_op("mulh_2p32", 5'd12, 32'h40000000, 32'd4, 32'h00000001, 33);

    run_op("div_ovf",  5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_op("rem_ovf",  5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("div_m7",   5'd15, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem_m7",   5'd17, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu_z",   5'd16, 32'd7, 32'd0, 32'hFFFFFFFF, 33);
    run_op("remu_z",   5'd18, 32'd7, 32'd0, 32'h00000007, 33);
    run_op("div_m7z",  5'd15, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 33);
    run_op("rem_m7z",  5'd17, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 33);
    run_op("divu",     5'd16, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu",     5'd18, 32'd100, 32'd7, 32'd2, 33);

    // Backpressure: result held, next request waits for the handshake
    out_ready = 1'b0;
    op = 5'd0; src1 = 32'd2; src2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 5'd1; src1 = 32'd10; src2 = 32'd4;
    check("bp_v0", 32'(out_valid), 32'd1);
    check("bp_r0", result, 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_v", 32'(out_valid), 32'd1);
      check("bp_hold_r", result, 32'd5);
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    check("bp_hs_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("bp_post_v", 32'(out_valid), 32'd0);
    check("bp_post_rdy", 32'(in_ready), 32'd1);
    check("bp_post_r", result, 32'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_v", 32'(out_valid), 32'd1);
    check("bp_next_r", result, 32'd6);
    @(posedge clk); #1;

    // Asynchronous reset mid-divide
    op = 5'd15; src1 = 32'd1000; src2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_v", 32'(out_valid), 32'd0);
    check("arst_rdy", 32'(in_ready), 32'd1);
    check("arst_res", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("post_rst_add", 5'd0, 32'd1, 32'd1, 32'd2, 1);

    // Flush mid-multiply
    op = 5'd11; src1 = 32'd123; src2 = 32'd456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_rdy", 32'(in_ready), 32'd1);
    check("fl_v", 32'(out_valid), 32'd0);
    check("fl_res", result, 32'd2);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("fl_nopulse", 32'(pulses), 32'd0);
    run_op("post_fl_add", 5'd0, 32'h10, 32'h20, 32'h30, 1);

    // Accept coinciding with flush is dropped
    op = 5'd0; src1 = 32'd1; src2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flacc_v", 32'(out_valid), 32'd0);
    check("flacc_rdy", 32'(in_ready), 32'd1);
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("flacc_nopulse", 32'(pulses), 32'd0);
    check("flacc_res", result, 32'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_md_seq.md
ALU_MD_SEQ -- requirements
Module: alu_md_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width, any even value 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN): shift-amount width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1: synchronous abort of any operation in flight.
REQ-006 SHALL have port in_valid  input  1: request present on op/src1/src2.
REQ-007 SHALL have port in_ready  output  1: block can accept a request.
REQ-008 SHALL have port op  input  5: encoded operation (REQ-012).
REQ-009 SHALL have ports src1, src2  input  XLEN: operands.
REQ-010 SHALL have port out_valid  output  1: result is valid.
REQ-011 SHALL have ports out_ready  input  1 (consumer accepts) and result  output  XLEN (registered result).

Function
REQ-012 SHALL decode op: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 LUI (result=src2), 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU; codes 19-31 produce result 0 with single-cycle timing.
REQ-013 SHALL implement states IDLE, CALC, DONE; in_ready = 1 only in IDLE; accept = in_valid & in_ready at a rising edge.
REQ-014 SHALL, for ops 0-10 and 19-31, go IDLE->DONE on accept with result registered on that edge: out_valid high the cycle after accept.
REQ-015 SHALL, for ops 11-18, go IDLE->CALC on accept, latch operands, load iteration counter with XLEN, decrement once per cycle, and go CALC->DONE when the counter reaches 1 and decrements: out_valid rises exactly XLEN+1 cycles after accept, independent of operand values.
REQ-016 SHALL implement multiply as one-bit-per-cycle shift-add on operand magnitudes into a 2*XLEN product, negated at completion when operand signs (per op signedness; MULHSU: src1 signed, src2 unsigned) differ; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits.
REQ-017 SHALL implement divide as one-bit-per-cycle restoring division on magnitudes; quotient negated if signed operand signs differ; remainder takes dividend sign.
REQ-018 SHALL, on divide by zero, return quotient all-ones (DIV and DIVU) and remainder = src1, with unchanged latency.
REQ-019 SHALL, on signed overflow (src1 = most-negative, src2 = all-ones), return DIV = src1, REM = 0.
REQ-020 SHALL compute ADD/SUB modulo 2^XLEN, SLT/SLTU as 0/1 zero-extended, shifts by src2[SHW-1:0] only, SRA sign-filling.
REQ-021 SHALL hold result and out_valid stable in DONE while out_ready = 0; DONE->IDLE on out_valid & out_ready; in_ready is not asserted in that same cycle (no bypass).
REQ-022 SHALL treat flush as highest priority below rst: any state -> IDLE on next edge, out_valid 0, result unchanged, in-flight request discarded; an accept coinciding with flush is discarded.
REQ-023 SHALL ignore op/src1/src2 changes while not in IDLE.

Reset
REQ-024 SHALL, while rst = 1, force state IDLE, out_valid 0, result 0, counter 0, in_ready 1, asynchronously to clk.
REQ-025 SHALL abandon any in-flight operation on rst with no output pulse after release; first accept possible at first edge with rst = 0.

Verification (XLEN = 32)
REQ-026 SHALL cover: ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, out_valid exactly 1 cycle after accept; SRA 0x80000000 by src2 0x00000024 -> shift 4, 0xF8000000.
REQ-027 SHALL cover: MUL/MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001 / 0xFFFFFFFE; MULH same operands -> 0x00000000; out_valid exactly 33 cycles after accept.
REQ-028 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; DIV -7 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-029 SHALL cover: DIVU 7 / 0 -> 0xFFFFFFFF, REMU 7 / 0 -> 0x00000007, latency 33 cycles.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles in DONE -> result, out_valid stable, in_ready 0; new request accepted only from cycle after handshake.
REQ-031 SHALL cover: rst asserted 10 cycles into DIV -> out_valid 0 and in_ready 1 immediately; flush 10 cycles into MUL -> IDLE next cycle, no out_valid pulse, following ADD returns correctly.
